wb_traffic_gen: RTL and testbench
=================================

# wb_traffic_gen

Parametrised Wishbone master traffic generator and self-checker that drives the SDRAM controller's Wishbone port in place of hand-written bench stimulus. It writes a programmable number of bursts to a base address, reads them back, and compares every returned word against a regenerated expected pattern. Data width, address width, burst-length width and pattern mode are all generic, so one block serves the 8-, 16- and 32-bit SDRAM builds.

## Interface
- DW, 32, Wishbone data width (8, 16 or 32)
- AW, 26, Wishbone byte-address width
- BL_W, 5, burst-length field width
- NB_W, 8, burst-count field width
- SEED, 32'hACE1_2468, LFSR seed (used only with WBTG_LFSR_EN)

- wb_clk_i  in  1  clock; all logic on rising edge
- wb_rst_i  in  1  asynchronous, active-high reset
- sdr_init_done  in  1  controller initialisation complete
- start  in  1  one-cycle pulse; begins a run
- base_addr  in  AW  byte address of first beat, sampled on start
- burst_len  in  BL_W  beats per burst, sampled on start; 0 means 2^BL_W
- num_bursts  in  NB_W  bursts per run, sampled on start; 0 means 2^NB_W
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  strobe
- wb_we_o  out  1  write enable
- wb_addr_o  out  AW  byte address
- wb_sel_o  out  DW/8  byte selects, always all ones
- wb_dat_o  out  DW  write data
- wb_dat_i  in  DW  read data
- wb_ack_i  in  1  acknowledge
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- err_cnt  out  16  mismatching read beats, saturates at 16'hFFFF
- first_err_addr  out  AW  address of first mismatch in the run

## Operation
- States: IDLE, WAIT_INIT, WR, WR_GAP, RD, RD_GAP, FINISH.
- IDLE: on start, latch inputs, clear err_cnt and first_err_addr, go to WAIT_INIT. A start pulse while busy is ignored.
- WAIT_INIT: stay until sdr_init_done=1, then go to WR.
- WR: cyc=stb=we=1. Each ack advances to the next beat: address += DW/8, next data. On the last beat's ack, drop cyc/stb and go to WR_GAP. The write phase covers all bursts.
- WR_GAP: one idle cycle with cyc=0. Increment the burst counter. If bursts remain, return to WR; otherwise reset the address to base_addr, reset the pattern generator, and go to RD.
- RD and RD_GAP: same sequencing as WR and WR_GAP with we=0. On every read ack, compare wb_dat_i with the expected word. On mismatch, increment err_cnt (saturating). On the first mismatch only, capture wb_addr_o into first_err_addr.
- FINISH: one cycle. Pulse done, deassert busy, go to IDLE.
- Address arithmetic: modulo 2^AW, so the address wraps silently past the top.
- Default pattern: data = beat byte address zero-extended or truncated to DW, XOR {DW/8{burst_index[7:0]}}.
- sdr_init_done dropping mid-run has no effect; the run continues.

## Timing
- Reset values: wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_addr_o=0, wb_dat_o=0, wb_sel_o=all ones, busy=0, done=0, err_cnt=0, first_err_addr=0, state=IDLE.
- busy rises the cycle after start.
- With sdr_init_done already high, cyc/stb assert 2 cycles after start (WAIT_INIT takes 1 cycle).
- All outputs are registered.
- A new beat's address and data appear in the cycle after ack. stb stays high between beats of one burst and never waits on ack.
- Zero-wait-state slave: one beat per cycle. Total run length = 2·N·(L+1) + 3 cycles, where N = bursts and L = beats per burst.
- err_cnt and first_err_addr update the cycle after the offending ack and hold until the next accepted start.
- wb_rst_i mid-run: everything returns to reset values asynchronously and no done pulse is generated.

## Configuration
- WBTG_LFSR_EN defined: data comes from a 32-bit Galois LFSR (polynomial x^32+x^22+x^2+x+1) seeded with SEED, advanced once per beat, with the low DW bits used. The LFSR is reseeded on entry to RD so the read phase regenerates the same sequence.
- WBTG_LFSR_EN undefined: the address-based pattern is used and no LFSR flops exist.

## Test plan
- DW=32, base 0x100, burst_len 4, num_bursts 2, zero-wait memory: write addresses run 0x100–0x11C, done arrives 2·2·5+3 = 23 cycles after start, err_cnt=0.
- Same run with memory bit 0 flipped at 0x108 on readback: err_cnt=1, first_err_addr=0x108.
- burst_len=0, num_bursts=1, DW=8: 32 beats with addresses stepping by 1, and cyc stays high for all 32 acks.
- sdr_init_done held low for 50 cycles after start: no stb during those cycles; the first stb appears the cycle after sdr_init_done rises.
- base 2^AW−8, DW=32, burst_len 4: addresses run 2^AW−8, 2^AW−4, 0x0, 0x4 with no error; a start pulse mid-run is ignored.
- wb_rst_i asserted during RD: all outputs go to reset values immediately and no done pulse occurs. A following start runs normally.

Source files
------------

// File: rtl/wb_traffic_gen_if.sv
// Wishbone bus bundle between the traffic generator (master) and the memory
// controller port (slave). Signal names keep the master's point of view.
interface wb_traffic_gen_if #(
    parameter int DW = 32,
    parameter int AW = 26
) ();
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic              wb_we_o;
    logic [AW-1:0]     wb_addr_o;
    logic [DW/8-1:0]   wb_sel_o;
    logic [DW-1:0]     wb_dat_o;
    logic [DW-1:0]     wb_dat_i;
    logic              wb_ack_i;

    modport master (
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_sel_o, wb_dat_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_sel_o, wb_dat_o,
        output wb_dat_i, wb_ack_i
    );
endinterface

// File: rtl/wb_traffic_gen.sv
// Wishbone master traffic generator and read-back checker.
// Writes num_bursts bursts of burst_len beats starting at base_addr, then
// reads the same range back and counts mismatching beats.
// Optional feature macro: WBTG_LFSR_EN selects a 32-bit Galois LFSR data
// pattern instead of the default address-based pattern.
module wb_traffic_gen #(
    parameter int          DW   = 32,
    parameter int          AW   = 26,
    parameter int          BL_W = 5,
    parameter int          NB_W = 8,
    parameter logic [31:0] SEED = 32'hACE1_2468
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    wb_traffic_gen_if.master  wb,
    input  logic              sdr_init_done,
    input  logic              start,
    input  logic [AW-1:0]     base_addr,
    input  logic [BL_W-1:0]   burst_len,
    input  logic [NB_W-1:0]   num_bursts,
    output logic              busy,
    output logic              done,
    output logic [15:0]       err_cnt,
    output logic [AW-1:0]     first_err_addr
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WAIT_INIT = 3'd1,
        S_WR        = 3'd2,
        S_WR_GAP    = 3'd3,
        S_RD        = 3'd4,
        S_RD_GAP    = 3'd5,
        S_FINISH    = 3'd6
    } state_t;

    localparam logic [AW-1:0]   ADDR_STEP = AW'(DW/8);
    localparam logic [BL_W:0]   BEAT_ONE  = {{BL_W{1'b0}}, 1'b1};
    localparam logic [NB_W:0]   BURST_ONE = {{NB_W{1'b0}}, 1'b1};

    state_t            state_q;
    logic              cyc_q;
    logic              stb_q;
    logic              we_q;
    logic [AW-1:0]     addr_q;
    logic [DW-1:0]     dat_q;
    logic              busy_q;
    logic              done_q;
    logic [15:0]       err_cnt_q;
    logic [AW-1:0]     first_err_q;
    logic [AW-1:0]     base_q;
    logic [BL_W:0]     beats_q;      // beats per burst, 1 .. 2^BL_W
    logic [NB_W:0]     bursts_q;     // bursts per run, 1 .. 2^NB_W
    logic [BL_W:0]     beat_cnt_q;
    logic [NB_W:0]     burst_cnt_q;

    logic [AW-1:0]     addr_step_d;
    logic [BL_W:0]     beat_inc_d;
    logic              last_beat_d;
    logic [NB_W:0]     burst_inc_d;
    logic              last_burst_d;
    logic [DW-1:0]     pat_start_d;  // first word of a phase
    logic [DW-1:0]     pat_beat_d;   // word for the next beat inside a burst
    logic [DW-1:0]     pat_burst_d;  // word for the first beat of the next burst

    // Beat/burst bookkeeping shared by the write and read phases.
    always_comb begin
        addr_step_d  = addr_q + ADDR_STEP;
        beat_inc_d   = beat_cnt_q + BEAT_ONE;
        last_beat_d  = (beat_inc_d == beats_q);
        burst_inc_d  = burst_cnt_q + BURST_ONE;
        last_burst_d = (burst_inc_d == bursts_q);
    end

`ifdef WBTG_LFSR_EN
    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;
    logic        lfsr_load_s;
    logic        lfsr_adv_s;

    // Galois step for x^32+x^22+x^2+x+1 plus load/advance decode.
    always_comb begin
        if (lfsr_q[0]) begin
            lfsr_d = (lfsr_q >> 1) ^ 32'h8020_0003;
        end else begin
            lfsr_d = lfsr_q >> 1;
        end
        lfsr_load_s = ((state_q == S_WAIT_INIT) && sdr_init_done) ||
                      ((state_q == S_WR_GAP) && last_burst_d);
        lfsr_adv_s  = ((state_q == S_WR) || (state_q == S_RD)) && wb.wb_ack_i;
    end

    // LFSR state: reseeded at the start of each phase, one step per beat.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            lfsr_q <= SEED;
        end else if (lfsr_load_s) begin
            lfsr_q <= SEED;
        end else if (lfsr_adv_s) begin
            lfsr_q <= lfsr_d;
        end
    end

    // Pattern words taken from the low DW bits of the LFSR.
    always_comb begin
        pat_start_d = SEED[DW-1:0];
        pat_beat_d  = lfsr_d[DW-1:0];
        pat_burst_d = dat_q;
    end
`else
    // Address pattern: beat address fitted to DW, XOR the burst index byte.
    function automatic logic [DW-1:0] addr_pattern(input logic [AW-1:0] a,
                                                   input logic [NB_W:0] b);
        logic [AW+DW-1:0] a_ext;
        logic [NB_W+8:0]  b_ext;
        a_ext = {{DW{1'b0}}, a};
        b_ext = {8'h00, b};
        return a_ext[DW-1:0] ^ {(DW/8){b_ext[7:0]}};
    endfunction

    // Pattern words derived from the address the word will be sent with.
    always_comb begin
        pat_start_d = addr_pattern(base_q, {(NB_W+1){1'b0}});
        pat_beat_d  = addr_pattern(addr_step_d, burst_cnt_q);
        pat_burst_d = addr_pattern(addr_q, burst_inc_d);
    end
`endif

    // Main sequencer: bus cycles, run bookkeeping and read-back checking.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q     <= S_IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= {AW{1'b0}};
            dat_q       <= {DW{1'b0}};
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_cnt_q   <= 16'h0000;
            first_err_q <= {AW{1'b0}};
            base_q      <= {AW{1'b0}};
            beats_q     <= {(BL_W+1){1'b0}};
            bursts_q    <= {(NB_W+1){1'b0}};
            beat_cnt_q  <= {(BL_W+1){1'b0}};
            burst_cnt_q <= {(NB_W+1){1'b0}};
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        base_q      <= base_addr;
                        beats_q     <= (burst_len == {BL_W{1'b0}}) ?
                                       {1'b1, {BL_W{1'b0}}} : {1'b0, burst_len};
                        bursts_q    <= (num_bursts == {NB_W{1'b0}}) ?
                                       {1'b1, {NB_W{1'b0}}} : {1'b0, num_bursts};
                        err_cnt_q   <= 16'h0000;
                        first_err_q <= {AW{1'b0}};
                        busy_q      <= 1'b1;
                        state_q     <= S_WAIT_INIT;
                    end
                end
                S_WAIT_INIT: begin
                    if (sdr_init_done) begin
                        cyc_q       <= 1'b1;
                        stb_q       <= 1'b1;
                        we_q        <= 1'b1;
                        addr_q      <= base_q;
                        dat_q       <= pat_start_d;
                        beat_cnt_q  <= {(BL_W+1){1'b0}};
                        burst_cnt_q <= {(NB_W+1){1'b0}};
                        state_q     <= S_WR;
                    end
                end
                S_WR, S_RD: begin
                    if (wb.wb_ack_i) begin
                        addr_q <= addr_step_d;
                        dat_q  <= pat_beat_d;
                        if ((state_q == S_RD) && (wb.wb_dat_i != dat_q)) begin
                            if (err_cnt_q == 16'h0000) begin
                                first_err_q <= addr_q;
                            end
                            if (err_cnt_q != 16'hFFFF) begin
                                err_cnt_q <= err_cnt_q + 16'h0001;
                            end
                        end
                        if (last_beat_d) begin
                            cyc_q      <= 1'b0;
                            stb_q      <= 1'b0;
                            we_q       <= 1'b0;
                            beat_cnt_q <= {(BL_W+1){1'b0}};
                            state_q    <= (state_q == S_WR) ? S_WR_GAP : S_RD_GAP;
                        end else begin
                            beat_cnt_q <= beat_inc_d;
                        end
                    end
                end
                S_WR_GAP: begin
                    cyc_q <= 1'b1;
                    stb_q <= 1'b1;
                    if (!last_burst_d) begin
                        burst_cnt_q <= burst_inc_d;
                        we_q        <= 1'b1;
                        dat_q       <= pat_burst_d;
                        state_q     <= S_WR;
                    end else begin
                        // Rewind address and pattern so reads regenerate the writes.
                        burst_cnt_q <= {(NB_W+1){1'b0}};
                        we_q        <= 1'b0;
                        addr_q      <= base_q;
                        dat_q       <= pat_start_d;
                        state_q     <= S_RD;
                    end
                end
                S_RD_GAP: begin
                    if (!last_burst_d) begin
                        burst_cnt_q <= burst_inc_d;
                        cyc_q       <= 1'b1;
                        stb_q       <= 1'b1;
                        dat_q       <= pat_burst_d;
                        state_q     <= S_RD;
                    end else begin
                        state_q <= S_FINISH;
                    end
                end
                S_FINISH: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    cyc_q   <= 1'b0;
                    stb_q   <= 1'b0;
                    we_q    <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign wb.wb_cyc_o  = cyc_q;
    assign wb.wb_stb_o  = stb_q;
    assign wb.wb_we_o   = we_q;
    assign wb.wb_addr_o = addr_q;
    assign wb.wb_dat_o  = dat_q;
    assign wb.wb_sel_o  = {(DW/8){1'b1}};
    assign busy           = busy_q;
    assign done           = done_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_addr = first_err_q;

endmodule

// File: tb/tb_wb_traffic_gen.sv
// Directed bench for wb_traffic_gen (DW=32, AW=26) against a zero-wait
// Wishbone memory with optional single-bit read corruption.
module tb_wb_traffic_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        sdr_init_done;
    logic        start;
    logic [25:0] base_addr;
    logic [4:0]  burst_len;
    logic [7:0]  num_bursts;
    logic        busy;
    logic        done;
    logic [15:0] err_cnt;
    logic [25:0] first_err_addr;

    wb_traffic_gen_if #(.DW(32), .AW(26)) wb ();

    wb_traffic_gen #(.DW(32), .AW(26), .BL_W(5), .NB_W(8)) dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .wb             (wb.master),
        .sdr_init_done  (sdr_init_done),
        .start          (start),
        .base_addr      (base_addr),
        .burst_len      (burst_len),
        .num_bursts     (num_bursts),
        .busy           (busy),
        .done           (done),
        .err_cnt        (err_cnt),
        .first_err_addr (first_err_addr)
    );

    always #5 clk = ~clk;

    // Zero-wait memory slave
    logic [31:0] mem [0:255];
    logic        inj_en;
    logic [25:0] inj_a;
    logic [25:0] inj_b;

    assign wb.wb_ack_i = wb.wb_cyc_o & wb.wb_stb_o;
    assign wb.wb_dat_i = mem[wb.wb_addr_o[9:2]] ^
        ((inj_en && ((wb.wb_addr_o == inj_a) || (wb.wb_addr_o == inj_b))) ? 32'h0000_0001 : 32'h0000_0000);

    always @(posedge clk) begin
        if (wb.wb_cyc_o && wb.wb_stb_o && wb.wb_we_o) mem[wb.wb_addr_o[9:2]] <= wb.wb_dat_o;
    end

    int n_vec  = 0;
    int n_miss = 0;

    int done_at, first_stb_at, max_run;
    int start_pulse_k, init_rise_k, init_fall_k;
    logic busy_k1, busy_at_done;
    logic [25:0] wr_q[$];
    logic [25:0] rd_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observe one run cycle by cycle (k = cycles after the start edge).
    task automatic run(input int limit);
        int cur;
        cur = 0; done_at = -1; first_stb_at = -1; max_run = 0;
        busy_k1 = 1'b0; busy_at_done = 1'b1;
        wr_q.delete(); rd_q.delete();
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            start = (k == start_pulse_k);
            if (k == init_rise_k) sdr_init_done = 1'b1;
            if (k == init_fall_k) sdr_init_done = 1'b0;
            if (k == 1) busy_k1 = busy;
            if (wb.wb_stb_o && (first_stb_at < 0)) first_stb_at = k;
            if (wb.wb_ack_i) begin
                cur++;
                if (cur > max_run) max_run = cur;
                if (wb.wb_we_o) wr_q.push_back(wb.wb_addr_o);
                else            rd_q.push_back(wb.wb_addr_o);
            end else begin
                cur = 0;
            end
            if (done) begin
                done_at = k;
                busy_at_done = busy;
                break;
            end
        end
    endtask

    task automatic launch(input logic [25:0] b, input logic [4:0] l, input logic [7:0] n);
        @(negedge clk);
        base_addr = b; burst_len = l; num_bursts = n;
        start = 1'b1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sdr_init_done = 1'b1;
        base_addr = 26'h0; burst_len = 5'd0; num_bursts = 8'd0;
        inj_en = 1'b0; inj_a = 26'h0; inj_b = 26'h0;
        start_pulse_k = 0; init_rise_k = 0; init_fall_k = 0;
        repeat (2) @(negedge clk);

        chk("rst_cyc",  {63'd0, wb.wb_cyc_o}, 64'd0);
        chk("rst_stb",  {63'd0, wb.wb_stb_o}, 64'd0);
        chk("rst_we",   {63'd0, wb.wb_we_o},  64'd0);
        chk("rst_addr", {38'd0, wb.wb_addr_o}, 64'd0);
        chk("rst_dat",  {32'd0, wb.wb_dat_o}, 64'd0);
        chk("rst_sel",  {60'd0, wb.wb_sel_o}, 64'hF);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_err",  {48'd0, err_cnt}, 64'd0);
        chk("rst_ferr", {38'd0, first_err_addr}, 64'd0);
        rst = 1'b0;

        // A: base 0x100, 4 beats x 2 bursts, clean memory
        launch(26'h100, 5'd4, 8'd2);
        run(100);
        chk("A_busy_k1",   {63'd0, busy_k1}, 64'd1);
        chk("A_first_stb", 64'(first_stb_at), 64'd2);
        chk("A_done_at",   64'(done_at), 64'd23);
        chk("A_busy_done", {63'd0, busy_at_done}, 64'd0);
        chk("A_nwr",       64'(wr_q.size()), 64'd8);
        chk("A_wr0",       {38'd0, wr_q[0]}, 64'h100);
        chk("A_wr5",       {38'd0, wr_q[5]}, 64'h114);
        chk("A_wr7",       {38'd0, wr_q[7]}, 64'h11C);
        chk("A_nrd",       64'(rd_q.size()), 64'd8);
        chk("A_rd0",       {38'd0, rd_q[0]}, 64'h100);
        chk("A_maxrun",    64'(max_run), 64'd4);
        chk("A_mem100",    {32'd0, mem[8'h40]}, 64'h0000_0100);
        chk("A_mem10C",    {32'd0, mem[8'h43]}, 64'h0000_010C);
        chk("A_mem110",    {32'd0, mem[8'h44]}, 64'h0101_0011);
        chk("A_mem11C",    {32'd0, mem[8'h47]}, 64'h0101_001D);
        chk("A_err",       {48'd0, err_cnt}, 64'd0);

        // B: same run, bit 0 flipped at 0x108 on readback
        inj_en = 1'b1; inj_a = 26'h108; inj_b = 26'h108;
        launch(26'h100, 5'd4, 8'd2);
        run(100);
        chk("B_done_at", 64'(done_at), 64'd23);
        chk("B_err",     {48'd0, err_cnt}, 64'd1);
        chk("B_ferr",    {38'd0, first_err_addr}, 64'h108);

        // B2: two corrupted words, only the first address is captured
        inj_a = 26'h104; inj_b = 26'h118;
        launch(26'h100, 5'd4, 8'd2);
        run(100);
        chk("B2_err",  {48'd0, err_cnt}, 64'd2);
        chk("B2_ferr", {38'd0, first_err_addr}, 64'h104);
        run(5);
        chk("B2_hold_err",  {48'd0, err_cnt}, 64'd2);
        chk("B2_hold_ferr", {38'd0, first_err_addr}, 64'h104);
        inj_en = 1'b0;

        // C: burst_len 0 means 32 beats in a single burst
        launch(26'h0, 5'd0, 8'd1);
        run(200);
        chk("C_done_at", 64'(done_at), 64'd69);
        chk("C_nwr",     64'(wr_q.size()), 64'd32);
        chk("C_wr1",     {38'd0, wr_q[1]}, 64'h4);
        chk("C_wr31",    {38'd0, wr_q[31]}, 64'h7C);
        chk("C_maxrun",  64'(max_run), 64'd32);
        chk("C_err",     {48'd0, err_cnt}, 64'd0);
        chk("C_ferr",    {38'd0, first_err_addr}, 64'd0);

        // D: init held low for 50 cycles, then dropped again mid-run
        sdr_init_done = 1'b0; init_rise_k = 51; init_fall_k = 54;
        launch(26'h200, 5'd2, 8'd1);
        run(200);
        chk("D_first_stb", 64'(first_stb_at), 64'd52);
        chk("D_done_at",   64'(done_at), 64'd59);
        chk("D_err",       {48'd0, err_cnt}, 64'd0);
        init_rise_k = 0; init_fall_k = 0; sdr_init_done = 1'b1;

        // E: address wrap at the top, extra start pulse mid-run
        start_pulse_k = 5;
        launch(26'h3FF_FFF8, 5'd4, 8'd1);
        run(100);
        start_pulse_k = 0;
        chk("E_done_at", 64'(done_at), 64'd13);
        chk("E_wr0",     {38'd0, wr_q[0]}, 64'h3FF_FFF8);
        chk("E_wr1",     {38'd0, wr_q[1]}, 64'h3FF_FFFC);
        chk("E_wr2",     {38'd0, wr_q[2]}, 64'h0);
        chk("E_wr3",     {38'd0, wr_q[3]}, 64'h4);
        chk("E_memtop",  {32'd0, mem[8'hFE]}, 64'h03FF_FFF8);
        chk("E_err",     {48'd0, err_cnt}, 64'd0);
        run(5);
        chk("E_no_rerun", {63'd0, busy}, 64'd0);

        // F: reset during the read phase
        launch(26'h100, 5'd4, 8'd2);
        run(14);
        chk("F_no_done", 64'(done_at), 64'hFFFF_FFFF_FFFF_FFFF);
        chk("F_in_rd",   64'(rd_q.size()), 64'd3);
        rst = 1'b1;
        #1;
        chk("F_cyc",  {63'd0, wb.wb_cyc_o}, 64'd0);
        chk("F_stb",  {63'd0, wb.wb_stb_o}, 64'd0);
        chk("F_addr", {38'd0, wb.wb_addr_o}, 64'd0);
        chk("F_dat",  {32'd0, wb.wb_dat_o}, 64'd0);
        chk("F_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run(30);
        chk("F_no_done_after", 64'(done_at), 64'hFFFF_FFFF_FFFF_FFFF);
        launch(26'h100, 5'd4, 8'd2);
        run(100);
        chk("F_rerun_done", 64'(done_at), 64'd23);
        chk("F_rerun_err",  {48'd0, err_cnt}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
